match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter: PAUSE_CYCLES, 65_000_000, idle gap before each shot (1 s at 65 MHz); minimum 1.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-004 game_state  input  g_state  current game state from the state selector.
REQ-005 shot_done  input  1  one-cycle pulse: the current shot has resolved.
REQ-006 shot_saved  input  1  outcome qualifier, valid only with shot_done (1 = keeper saved, 0 = goal).
REQ-007 shot_start  output  1  one-cycle pulse commanding the ball generator to launch a shot.
REQ-008 saves  output  3  saves so far in the current match.
REQ-009 goals  output  3  goals conceded so far in the current match.
REQ-010 shots_taken  output  3  saves + goals.
REQ-011 match_end  output  1  level: match decided; feeds the state selector.
REQ-012 match_result  output  1  level, valid while match_end = 1: 1 = player (keeper) won.

Function
REQ-013 The FSM SHALL have the states IDLE, PAUSE, SHOT and DONE.
REQ-014 From every state, game_state != KEEPER SHALL force IDLE on the next edge; entering IDLE clears saves, goals, the pause counter, match_end and match_result.
REQ-015 IDLE -> PAUSE SHALL occur on the first cycle game_state == KEEPER; the pause counter loads 0.
REQ-016 PAUSE SHALL last exactly PAUSE_CYCLES cycles, then go to SHOT.
REQ-017 shot_start SHALL be 1 for exactly the first cycle spent in SHOT, once per shot.
REQ-018 In SHOT, shot_done SHALL increment saves if shot_saved = 1, else goals; the counts are visible the next cycle.
REQ-019 After the update, saves == SHOTS_TO_WIN or goals == SHOTS_TO_WIN SHALL go to DONE; otherwise go to PAUSE (reloaded).
REQ-020 In DONE: match_end = 1 and match_result = (saves == SHOTS_TO_WIN), both registered, asserted the cycle after the decisive shot_done; counts frozen.
REQ-021 DONE SHALL hold until game_state leaves KEEPER.
REQ-022 shot_done in IDLE, PAUSE or DONE SHALL be ignored (no count change).
REQ-023 shot_done coinciding with game_state != KEEPER: leaving KEEPER wins; no count update.
REQ-024 Counters SHALL never exceed SHOTS_TO_WIN; shots_taken never exceeds SHOTS_TOTAL (no wrap).
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 On rst: state IDLE; shot_start, saves, goals, shots_taken, match_end and match_result = 0; pause counter = 0.
REQ-027 rst mid-match SHALL abandon the match with no shot_start emitted in the following cycle.

Structure
REQ-028 SHOTS_TOTAL = 5 and SHOTS_TO_WIN = 3 SHALL be constants in game_pkg, beside g_state.
REQ-029 The match FSM state enum SHALL be local to the module.
REQ-030 The pause counter SHALL be a sub-module match_pause_timer (inputs: load, enable; output: one-cycle expired pulse; width from $clog2(PAUSE_CYCLES)).

Verification (PAUSE_CYCLES = 4)
REQ-031 Check REQ-015 to REQ-017: game_state START -> KEEPER at cycle 0 -> shot_start pulse at cycle 5, width 1.
REQ-032 Check REQ-020: three shot_done with shot_saved = 1 -> saves 1, 2, 3; match_end = 1 and match_result = 1 one cycle after the third; goals = 0.
REQ-033 Check REQ-024: sequence goal, save, goal, save, goal -> ends with goals = 3, saves = 2, shots_taken = 5, match_result = 0.
REQ-034 Check REQ-022: shot_done during PAUSE or DONE -> counts unchanged and no extra shot_start.
REQ-035 Check REQ-014 and REQ-021: in DONE, game_state -> LOSER -> next cycle match_end = 0 and counts = 0; a later game_state -> KEEPER starts a fresh match.
REQ-036 Check REQ-026 and REQ-027: rst asserted in SHOT with saves = 2 -> all outputs 0 next cycle; no shot_start until game_state re-enters KEEPER.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: the game state used by the state selector and
// the match scoring constants.
package game_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        KEEPER = 2'd1,
        WINNER = 2'd2,
        LOSER  = 2'd3
    } g_state;

    localparam int unsigned SHOTS_TOTAL  = 5;
    localparam int unsigned SHOTS_TO_WIN = 3;
    // Width of the saves/goals/shots_taken counters.
    localparam int unsigned CNT_W        = $clog2(SHOTS_TOTAL + 1);

endpackage

// File: rtl/match_pause_timer.sv
// Pause timer for the match controller.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : force the count back to zero (has priority)
//   enable_i    : count one cycle of pause
//   expired_o   : one-cycle pulse on the last enabled cycle of the pause
module match_pause_timer #(
    parameter int unsigned PAUSE_CYCLES = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is combinational so the caller can leave the pause on the
    // same edge that completes its PAUSE_CYCLES-th cycle.
    assign expired_o = enable_i && (count_q == LAST);

    // Next count.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = expired_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/match_controller.sv
// Penalty match controller: paces shots, keeps score and decides the match.
//   clk, rst      : clock, synchronous active-high reset
//   game_state    : current game state; only KEEPER runs a match
//   shot_done     : one-cycle pulse, current shot resolved
//   shot_saved    : qualifier of shot_done (1 = saved, 0 = goal)
//   shot_start    : one-cycle pulse launching a shot
//   saves, goals  : scores of the current match
//   shots_taken   : saves + goals
//   match_end     : match decided
//   match_result  : valid with match_end, 1 = keeper won
module match_controller
    import game_pkg::*;
#(
    parameter int unsigned PAUSE_CYCLES = 65_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  g_state           game_state,
    input  logic             shot_done,
    input  logic             shot_saved,
    output logic             shot_start,
    output logic [CNT_W-1:0] saves,
    output logic [CNT_W-1:0] goals,
    output logic [CNT_W-1:0] shots_taken,
    output logic             match_end,
    output logic             match_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        SHOT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIN     = CNT_W'(SHOTS_TO_WIN);
    localparam logic [CNT_W-1:0] WIN_M1  = CNT_W'(SHOTS_TO_WIN - 1);

    state_t           state_q, state_d;
    logic             shot_start_q, shot_start_d;
    logic [CNT_W-1:0] saves_q, saves_d;
    logic [CNT_W-1:0] goals_q, goals_d;
    logic [CNT_W-1:0] shots_q, shots_d;
    logic             match_end_q, match_end_d;
    logic             match_result_q, match_result_d;

    logic in_keeper;
    logic decisive;
    logic pause_expired;

    assign in_keeper = (game_state == KEEPER);
    // The pending shot reaches SHOTS_TO_WIN for whichever side it scores.
    assign decisive  = shot_saved ? (saves_q == WIN_M1) : (goals_q == WIN_M1);

    // Pause counter held at zero outside PAUSE, so every pause starts fresh.
    match_pause_timer #(
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) u_pause_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q != PAUSE),
        .enable_i  (state_q == PAUSE),
        .expired_o (pause_expired)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shot_start_q   <= 1'b0;
            saves_q        <= '0;
            goals_q        <= '0;
            shots_q        <= '0;
            match_end_q    <= 1'b0;
            match_result_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shot_start_q   <= shot_start_d;
            saves_q        <= saves_d;
            goals_q        <= goals_d;
            shots_q        <= shots_d;
            match_end_q    <= match_end_d;
            match_result_q <= match_result_d;
        end
    end

    // Next state; leaving KEEPER overrides everything else.
    always_comb begin
        state_d = state_q;
        if (!in_keeper) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PAUSE;
                PAUSE:   if (pause_expired) state_d = SHOT;
                SHOT:    if (shot_done) state_d = decisive ? DONE : PAUSE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        shot_start_d   = 1'b0;
        saves_d        = saves_q;
        goals_d        = goals_q;
        shots_d        = shots_q;
        match_end_d    = match_end_q;
        match_result_d = match_result_q;
        if (state_d == IDLE) begin
            saves_d        = '0;
            goals_d        = '0;
            shots_d        = '0;
            match_end_d    = 1'b0;
            match_result_d = 1'b0;
        end else begin
            shot_start_d = (state_q == PAUSE) && (state_d == SHOT);
            if ((state_q == SHOT) && shot_done) begin
                if (shot_saved) begin
                    saves_d = saves_q + CNT_W'(1);
                end else begin
                    goals_d = goals_q + CNT_W'(1);
                end
                shots_d = shots_q + CNT_W'(1);
                if (state_d == DONE) begin
                    match_end_d    = 1'b1;
                    match_result_d = (saves_d == WIN);
                end
            end
        end
    end

    assign shot_start   = shot_start_q;
    assign saves        = saves_q;
    assign goals        = goals_q;
    assign shots_taken  = shots_q;
    assign match_end    = match_end_q;
    assign match_result = match_result_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller with PAUSE_CYCLES = 4.
module tb_match_controller;
    import game_pkg::*;

    typedef struct packed {
        logic       ss;
        logic [2:0] sv;
        logic [2:0] gl;
        logic [2:0] st;
        logic       me;
        logic       mr;
    } snap_t;

    typedef struct packed {
        int unsigned cyc;
        snap_t       s;
    } exp_t;

    logic       clk;
    logic       rst;
    g_state     game_state;
    logic       shot_done;
    logic       shot_saved;
    logic       shot_start;
    logic [2:0] saves;
    logic [2:0] goals;
    logic [2:0] shots_taken;
    logic       match_end;
    logic       match_result;

    int unsigned cyc;
    int          n_vec;
    int          n_err;
    bit          mon_en;
    exp_t        exp_q[$];
    snap_t       cur;
    snap_t       prev;

    match_controller #(
        .PAUSE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .shot_done    (shot_done),
        .shot_saved   (shot_saved),
        .shot_start   (shot_start),
        .saves        (saves),
        .goals        (goals),
        .shots_taken  (shots_taken),
        .match_end    (match_end),
        .match_result (match_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t mk(input logic ss, input logic [2:0] sv, input logic [2:0] gl,
                                 input logic me, input logic mr);
        snap_t s;
        s.ss = ss;
        s.sv = sv;
        s.gl = gl;
        s.st = 3'(sv + gl);
        s.me = me;
        s.mr = mr;
        return s;
    endfunction

    task automatic push(input snap_t s, input int unsigned at);
        exp_t e;
        e.cyc = at;
        e.s   = s;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: any shot_start pulse or change of score/result is a DUT event.
    always @(negedge clk) begin
        exp_t e;
        cur = mk(shot_start, saves, goals, match_end, match_result);
        cur.st = shots_taken;
        if (mon_en && (cur.ss || (cur.sv !== prev.sv) || (cur.gl !== prev.gl) ||
                       (cur.st !== prev.st) || (cur.me !== prev.me) || (cur.mr !== prev.mr))) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d got ss=%b sv=%0d gl=%0d st=%0d me=%b mr=%b, none expected",
                         cyc, cur.ss, cur.sv, cur.gl, cur.st, cur.me, cur.mr);
            end else begin
                e = exp_q.pop_front();
                if ((e.s !== cur) || (e.cyc != cyc)) begin
                    n_err++;
                    $display("FAIL event cyc=%0d got ss=%b sv=%0d gl=%0d st=%0d me=%b mr=%b expected cyc=%0d ss=%b sv=%0d gl=%0d st=%0d me=%b mr=%b",
                             cyc, cur.ss, cur.sv, cur.gl, cur.st, cur.me, cur.mr,
                             e.cyc, e.s.ss, e.s.sv, e.s.gl, e.s.st, e.s.me, e.s.mr);
                end
            end
        end
        prev = cur;
    end

    // Enter KEEPER: first shot_start five cycles later with a clean score.
    task automatic start_match();
        game_state = KEEPER;
        push(mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0), cyc + 5);
        repeat (5) tick();
    endtask

    // Called in the first SHOT cycle; resolves the shot with expected score.
    // inj drives stray shot_done pulses in the following PAUSE or DONE.
    task automatic shot(input logic saved, input logic [2:0] e_sv, input logic [2:0] e_gl,
                        input logic e_end, input logic e_res, input bit inj);
        push(mk(1'b0, e_sv, e_gl, e_end, e_res), cyc + 1);
        shot_done  = 1'b1;
        shot_saved = saved;
        tick();
        shot_done  = 1'b0;
        shot_saved = 1'b0;
        if (!e_end) begin
            push(mk(1'b1, e_sv, e_gl, 1'b0, 1'b0), cyc + 4);
            for (int i = 0; i < 4; i++) begin
                shot_done  = inj && (i == 1);
                shot_saved = 1'b1;
                tick();
            end
            shot_done  = 1'b0;
            shot_saved = 1'b0;
        end else if (inj) begin
            for (int i = 0; i < 3; i++) begin
                shot_done  = 1'b1;
                shot_saved = i[0];
                tick();
                shot_done  = 1'b0;
                tick();
            end
        end
    endtask

    initial begin
        cyc        = 0;
        n_vec      = 0;
        n_err      = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        game_state = START;
        shot_done  = 1'b0;
        shot_saved = 1'b0;
        repeat (3) tick();

        check("rst_shot_start", {2'b0, shot_start}, 3'd0);
        check("rst_saves", saves, 3'd0);
        check("rst_goals", goals, 3'd0);
        check("rst_shots_taken", shots_taken, 3'd0);
        check("rst_match_end", {2'b0, match_end}, 3'd0);
        check("rst_match_result", {2'b0, match_result}, 3'd0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();

        // Keeper wins 3-0; stray shot_done in PAUSE and DONE.
        start_match();
        shot(1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1);
        shot(1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        shot(1'b1, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        check("done_hold_match_end", {2'b0, match_end}, 3'd1);

        // Leave KEEPER from DONE: everything clears the next cycle.
        push(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0), cyc + 1);
        game_state = LOSER;
        tick();
        repeat (3) tick();

        // Fresh match: goal, save, goal, save, goal -> keeper loses 2-3.
        start_match();
        shot(1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        shot(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        shot(1'b0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
        shot(1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        shot(1'b0, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1);
        check("loss_shots_taken", shots_taken, 3'd5);
        push(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0), cyc + 1);
        game_state = START;
        tick();
        repeat (2) tick();

        // Reset in SHOT with two saves: all outputs clear, no shot_start.
        start_match();
        shot(1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        shot(1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        push(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0), cyc + 1);
        rst        = 1'b1;
        game_state = START;
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // shot_done together with leaving KEEPER: the clear wins.
        start_match();
        shot(1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        push(mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0), cyc + 1);
        game_state = START;
        shot_done  = 1'b1;
        shot_saved = 1'b1;
        tick();
        shot_done  = 1'b0;
        shot_saved = 1'b0;
        repeat (8) tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event expected at cyc=%0d ss=%b sv=%0d gl=%0d me=%b mr=%b, not seen",
                     e.cyc, e.s.ss, e.s.sv, e.s.gl, e.s.me, e.s.mr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
